// File: rtl/ppu_video_timing_scaler.sv
// ppu_video_timing_scaler
//   Video output stage between the PPU pixel source and the HDMI/DVI encoder.
//   Generates the raster (counters, sync, de, line/frame strobes), requests
//   source pixels one cycle ahead with integer up-scaling and centring, and
//   expands 15-bit colour to 24-bit RGB with border fill and scanline darkening.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   pixel                 source pixel {b,g,r} 5:5:5, valid one cycle after request
//   border_en             fill active area outside the image with BORDER_RGB
//   scanline_en           halve the last output row of each scaled source line
//   vga_hcounter/vcounter raster position
//   next_pixel_x/y        source column requested for the next cycle / source row
//   frame_start           pulse at h=0,v=0 (counter aligned)
//   line_start            pulse at h=0 (counter aligned)
//   hsync, vsync, de      timing outputs, one clock behind the counters
//   hdmi_r/g/b            8-bit colour, one clock behind the counters
module ppu_video_timing_scaler #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int          SRC_W      = 256,
  parameter int          SRC_H      = 240,
  parameter int          SCALE      = 2,
  parameter int          CNT_W      = 10,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      pixel,
  input  logic             border_en,
  input  logic             scanline_en,
  output logic [CNT_W-1:0] vga_hcounter,
  output logic [CNT_W-1:0] vga_vcounter,
  output logic [8:0]       next_pixel_x,
  output logic [7:0]       next_pixel_y,
  output logic             frame_start,
  output logic             line_start,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [7:0]       hdmi_r,
  output logic [7:0]       hdmi_g,
  output logic [7:0]       hdmi_b
);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t X_OFF  = cnt_t'((H_ACTIVE - SRC_W * SCALE) / 2);
  localparam cnt_t Y_OFF  = cnt_t'((V_ACTIVE - SRC_H * SCALE) / 2);
  localparam cnt_t WIN_W  = cnt_t'(SRC_W * SCALE);
  localparam cnt_t WIN_H  = cnt_t'(SRC_H * SCALE);
  localparam logic [1:0] PH_MAX = 2'(SCALE - 1);

  // run is clear for the first cycle after reset release so that the first
  // running cycle shows h=0,v=0 together with both strobes.
  logic       run;
  cnt_t       h, v;
  logic [1:0] hph, vph;

  cnt_t       h_n, v_n, la_h, la_v, la_dx, la_dy, nv_dy, dx, dy;
  logic       la_win, win, act, dark;
  logic [7:0] r8, g8, b8;

  assign vga_hcounter = h;
  assign vga_vcounter = v;

  always_comb begin
    h_n = '0;
    v_n = '0;
    if (run) begin
      if (h == H_LAST) begin
        h_n = '0;
        v_n = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_n = h + 1'b1;
        v_n = v;
      end
    end
    // Lookahead position: the column displayed one cycle after h_n.
    la_h = h_n + 1'b1;
    la_v = v_n;
    if (h_n == H_LAST) begin
      la_h = '0;
      la_v = (v_n == V_LAST) ? '0 : v_n + 1'b1;
    end
    // Unsigned offsets: positions left of/above the window wrap to large values,
    // so a single upper-bound compare tests window membership.
    la_dx  = la_h - X_OFF;
    la_dy  = la_v - Y_OFF;
    la_win = (la_dx < WIN_W) && (la_dy < WIN_H);
    nv_dy  = v_n - Y_OFF;
    dx     = h - X_OFF;
    dy     = v - Y_OFF;
    win    = (dx < WIN_W) && (dy < WIN_H);
    act    = (h < H_ACT) && (v < V_ACT);
    dark   = scanline_en && (SCALE >= 2) && (vph == PH_MAX);
    r8     = {pixel[4:0],   pixel[4:2]};
    g8     = {pixel[9:5],   pixel[9:7]};
    b8     = {pixel[14:10], pixel[14:12]};
    if (dark) begin
      r8 = r8 >> 1;
      g8 = g8 >> 1;
      b8 = b8 >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run          <= 1'b0;
      h            <= '0;
      v            <= '0;
      hph          <= '0;
      vph          <= '0;
      next_pixel_x <= '0;
      next_pixel_y <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      de           <= 1'b0;
      hdmi_r       <= '0;
      hdmi_g       <= '0;
      hdmi_b       <= '0;
    end else begin
      run         <= 1'b1;
      h           <= h_n;
      v           <= v_n;
      line_start  <= (h_n == '0);
      frame_start <= (h_n == '0) && (v_n == '0);

      // Horizontal source column: restart at the window's first column,
      // step once per SCALE output columns.
      if (!la_win || la_dx == '0) begin
        next_pixel_x <= '0;
        hph          <= '0;
      end else if (hph == PH_MAX) begin
        next_pixel_x <= next_pixel_x + 1'b1;
        hph          <= '0;
      end else begin
        hph <= hph + 1'b1;
      end

      // Vertical source row: same scheme, stepped once per line.
      if (h_n == '0) begin
        if (nv_dy >= WIN_H || nv_dy == '0) begin
          next_pixel_y <= '0;
          vph          <= '0;
        end else if (vph == PH_MAX) begin
          next_pixel_y <= next_pixel_y + 1'b1;
          vph          <= '0;
        end else begin
          vph <= vph + 1'b1;
        end
      end

      if (run) begin
        de    <= act;
        hsync <= (h >= HS_BEG && h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync <= (v >= VS_BEG && v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        if (!act) begin
          {hdmi_r, hdmi_g, hdmi_b} <= '0;
        end else if (win) begin
          {hdmi_r, hdmi_g, hdmi_b} <= {r8, g8, b8};
        end else if (border_en) begin
          {hdmi_r, hdmi_g, hdmi_b} <= BORDER_RGB;
        end else begin
          {hdmi_r, hdmi_g, hdmi_b} <= '0;
        end
      end
    end
  end
endmodule
